// File: rtl/cache_controller.sv
// Load/store controller for a direct-mapped, write-through, no-write-allocate cache.
// Fills whole lines from memory on load misses and forwards every store to memory.
module cache_controller #(
  parameter int LOG_NUM_LINES  = 2,
  parameter int LOG_NUM_BLOCKS = 1,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  cache_write_en,
  output logic [DATA_WIDTH-1:0] cache_write_data,
  output logic [ADDR_WIDTH-1:0] cache_address,
  input  logic                  cache_hit,
  input  logic [DATA_WIDTH-1:0] cache_read_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  if (LOG_NUM_BLOCKS < 1 || ADDR_WIDTH <= LOG_NUM_LINES + LOG_NUM_BLOCKS) begin : bad_geometry
    $error("cache_controller: address width too narrow for the cache geometry");
  end

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOOKUP    = 3'd1;
  localparam logic [2:0] FILL      = 3'd2;
  localparam logic [2:0] WRITE_MEM = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;

  logic [2:0]                state;
  logic [LOG_NUM_BLOCKS-1:0] cnt;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic                      write_q;
  logic                      mem_req_q;
  logic                      ack;

  assign ack = mem_req_q & mem_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      mem_req_q  <= 1'b0;
      resp_rdata <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            write_q <= req_write;
            state   <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (write_q) begin
            mem_req_q <= 1'b1;
            state     <= WRITE_MEM;
          end else if (cache_hit) begin
            resp_rdata <= cache_read_data;
            if (hit_count != '1) hit_count <= hit_count + CNT_WIDTH'(1);
            state <= DONE;
          end else begin
            if (miss_count != '1) miss_count <= miss_count + CNT_WIDTH'(1);
            cnt   <= '0;
            state <= FILL;
          end
        end
        // Each block spends one cycle with mem_req low before requesting, which
        // also provides the mandatory gap after every ack.
        FILL: begin
          if (!mem_req_q) begin
            mem_req_q <= 1'b1;
          end else if (ack) begin
            mem_req_q <= 1'b0;
            if (cnt == addr_q[LOG_NUM_BLOCKS-1:0]) resp_rdata <= mem_rdata;
            if (cnt == '1) state <= DONE;
            else           cnt   <= cnt + LOG_NUM_BLOCKS'(1);
          end
        end
        WRITE_MEM: begin
          if (ack) begin
            mem_req_q <= 1'b0;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    cache_address = addr_q;
    if (state == FILL) cache_address = {addr_q[ADDR_WIDTH-1:LOG_NUM_BLOCKS], cnt};
  end

  always_comb begin
    cache_write_en   = 1'b0;
    cache_write_data = wdata_q;
    if (state == LOOKUP && write_q && cache_hit) begin
      cache_write_en = 1'b1;
    end else if (state == FILL) begin
      cache_write_data = mem_rdata;
      cache_write_en   = ack;
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign mem_req    = mem_req_q;
  assign mem_we     = (state == WRITE_MEM);
  assign mem_addr   = cache_address;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: behavioural cache and memory around the DUT, directed
// vectors, randomized traffic against an abstract line-residency model, and a reset abort.
module tb_cache_controller;

  localparam int CW   = 5;
  localparam int MAXC = 31;

  logic        clk, rst;
  logic        req_valid, req_ready, req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        cache_write_en;
  logic [31:0] cache_write_data;
  logic [7:0]  cache_address;
  logic        cache_hit;
  logic [31:0] cache_read_data;
  logic        mem_req, mem_we, mem_ack;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [CW-1:0] hit_count, miss_count;

  cache_controller #(.LOG_NUM_LINES(2), .LOG_NUM_BLOCKS(1), .DATA_WIDTH(32),
                     .ADDR_WIDTH(8), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .cache_write_en(cache_write_en), .cache_write_data(cache_write_data),
    .cache_address(cache_address), .cache_hit(cache_hit), .cache_read_data(cache_read_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1);
  end

  // Cache array: 4 lines x 2 blocks, tag = addr[7:3], shares the controller reset.
  logic        cv[4];
  logic [4:0]  ctag[4];
  logic [31:0] cdata[4][2];

  always_comb begin
    cache_hit       = cv[cache_address[2:1]] && (ctag[cache_address[2:1]] == cache_address[7:3]);
    cache_read_data = cdata[cache_address[2:1]][cache_address[0]];
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) cv[i] <= 1'b0;
    end else if (cache_write_en) begin
      cdata[cache_address[2:1]][cache_address[0]] <= cache_write_data;
      ctag[cache_address[2:1]] <= cache_address[7:3];
      cv[cache_address[2:1]]   <= 1'b1;
    end
  end

  // Memory responder: ack arrives in the ack_lat-th cycle of a held mem_req.
  logic [31:0] mem_env[256];
  logic [7:0]  rd_addr_q[$];
  logic [7:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          ack_lat;
  int          stray_req;

  initial begin
    int wait_cnt, stray_seen;
    for (int i = 0; i < 256; i++) mem_env[i] = {16'hC0DE, 8'h00, 8'(i)};
    mem_env[8'h14] = 32'hAAAA0001;
    mem_env[8'h15] = 32'hAAAA0002;
    mem_ack = 1'b0; mem_rdata = '0; wait_cnt = 0; stray_seen = 0;
    forever begin
      @(posedge clk); #1;
      if (mem_ack) begin
        mem_ack = 1'b0; wait_cnt = 0;
      end else if (stray_req != stray_seen) begin
        stray_seen = stray_req;
        mem_ack = 1'b1; mem_rdata = 32'hBADBAD00;
      end else if (mem_req) begin
        wait_cnt++;
        if (wait_cnt >= ack_lat) begin
          mem_ack = 1'b1; wait_cnt = 0;
          if (mem_we) begin
            mem_env[mem_addr] = mem_wdata;
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
          end else begin
            mem_rdata = mem_env[mem_addr];
            rd_addr_q.push_back(mem_addr);
          end
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Event counters and mem request stability, sampled mid-cycle.
  int cw_cnt, rv_cnt, ack_cnt, stab_err;
  initial begin
    logic       pend;
    logic [7:0] p_addr;
    logic       p_we;
    cw_cnt = 0; rv_cnt = 0; ack_cnt = 0; stab_err = 0; pend = 1'b0; p_addr = '0; p_we = 1'b0;
    forever begin
      @(negedge clk);
      if (cache_write_en) cw_cnt++;
      if (resp_valid) rv_cnt++;
      if (mem_ack) ack_cnt++;
      if (mem_req) begin
        if (pend && (mem_addr != p_addr || mem_we != p_we)) stab_err++;
        if (!pend) begin pend = 1'b1; p_addr = mem_addr; p_we = mem_we; end
        if (mem_ack) pend = 1'b0;
      end else begin
        pend = 1'b0;
      end
    end
  end

  int n_pass, n_total;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  // Issue one request from IDLE; returns latency from acceptance to resp_valid.
  task automatic do_txn(input bit wr, input logic [7:0] a, input logic [31:0] wd, input int al,
                        output int lat, output logic [31:0] rd, output int ncw,
                        output int rd0, output int nrd, output int wr0, output int nwr,
                        output int busy_err, output int nstab);
    int cw0, st0;
    ack_lat = al;
    cw0 = cw_cnt; st0 = stab_err; rd0 = rd_addr_q.size(); wr0 = wr_addr_q.size();
    busy_err = 0; lat = -1; rd = 'x;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (resp_valid) begin lat = c; rd = resp_rdata; break; end
      if (req_ready) busy_err++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    ncw = cw_cnt - cw0; nstab = stab_err - st0;
    nrd = rd_addr_q.size() - rd0; nwr = wr_addr_q.size() - wr0;
  endtask

  // Reference model: memory image and which line address each cache slot holds.
  logic [31:0] mem_ref[256];
  bit          res_v[4];
  logic [6:0]  res_line[4];
  int          m_hc, m_mc;
  logic [31:0] m_rd;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) res_v[i] = 1'b0;
    m_hc = 0; m_mc = 0; m_rd = '0;
  endtask

  task automatic model_txn(input string tag, input bit wr, input logic [7:0] a,
                           input logic [31:0] wd, input int al);
    int lat, ncw, rd0, nrd, wr0, nwr, be, ns, e_lat, e_cw, idx;
    logic [31:0] rd;
    bit hit;
    idx = int'(a[2:1]);
    hit = res_v[idx] && (res_line[idx] == a[7:1]);
    if (wr) begin
      mem_ref[a] = wd; e_lat = 2 + al; e_cw = hit ? 1 : 0;
    end else if (hit) begin
      m_hc = (m_hc < MAXC) ? m_hc + 1 : m_hc; e_lat = 2; e_cw = 0; m_rd = mem_ref[a];
    end else begin
      m_mc = (m_mc < MAXC) ? m_mc + 1 : m_mc; e_lat = 2 + 2 * (al + 1); e_cw = 2;
      m_rd = mem_ref[a]; res_v[idx] = 1'b1; res_line[idx] = a[7:1];
    end
    do_txn(wr, a, wd, al, lat, rd, ncw, rd0, nrd, wr0, nwr, be, ns);
    chk({tag, "_rdata"}, rd, m_rd);
    chk({tag, "_latency"}, lat, e_lat);
    chk({tag, "_cache_writes"}, ncw, e_cw);
    chk({tag, "_hit_count"}, 32'(hit_count), m_hc);
    chk({tag, "_miss_count"}, 32'(miss_count), m_mc);
  endtask

  typedef struct {
    bit wr; logic [7:0] addr; logic [31:0] wdata; int ack_lat;
    logic [31:0] rdata; int lat; int ncw; int nrd; int nwr; int hc; int mc;
  } vec_t;

  vec_t vt[10];

  initial begin
    int lat, ncw, rd0, nrd, wr0, nwr, be, ns, cw0, rv0, ack0;
    logic [31:0] rd;
    bit got_ack;
    logic [7:0] ra;

    vt[0] = '{1'b0, 8'h14, 32'h0,        1, 32'hAAAA0001,  6, 2, 2, 0, 0, 1};
    vt[1] = '{1'b0, 8'h15, 32'h0,        1, 32'hAAAA0002,  2, 0, 0, 0, 1, 1};
    vt[2] = '{1'b1, 8'h15, 32'hDEADBEEF, 1, 32'hAAAA0002,  3, 1, 0, 1, 1, 1};
    vt[3] = '{1'b0, 8'h15, 32'h0,        1, 32'hDEADBEEF,  2, 0, 0, 0, 2, 1};
    vt[4] = '{1'b1, 8'h40, 32'h12345678, 2, 32'hDEADBEEF,  4, 0, 0, 1, 2, 1};
    vt[5] = '{1'b0, 8'h40, 32'h0,        1, 32'h12345678,  6, 2, 2, 0, 2, 2};
    vt[6] = '{1'b0, 8'h41, 32'h0,        1, 32'hC0DE0041,  2, 0, 0, 0, 3, 2};
    vt[7] = '{1'b0, 8'h55, 32'h0,        5, 32'hC0DE0055, 14, 2, 2, 0, 3, 3};
    vt[8] = '{1'b0, 8'h14, 32'h0,        1, 32'hAAAA0001,  6, 2, 2, 0, 3, 4};
    vt[9] = '{1'b0, 8'h15, 32'h0,        1, 32'hDEADBEEF,  2, 0, 0, 0, 4, 4};

    for (int i = 0; i < 256; i++) mem_ref[i] = {16'hC0DE, 8'h00, 8'(i)};
    mem_ref[8'h14] = 32'hAAAA0001;
    mem_ref[8'h15] = 32'hAAAA0002;
    n_pass = 0; n_total = 0; ack_lat = 1; stray_req = 0;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;

    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_cache_write_en", cache_write_en, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_hit_count", 32'(hit_count), 0);
    chk("rst_miss_count", 32'(miss_count), 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_txn(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].ack_lat,
             lat, rd, ncw, rd0, nrd, wr0, nwr, be, ns);
      if (vt[i].wr) mem_ref[vt[i].addr] = vt[i].wdata;
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].rdata);
      chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
      chk($sformatf("vec%0d_cache_writes", i), ncw, vt[i].ncw);
      chk($sformatf("vec%0d_mem_reads", i), nrd, vt[i].nrd);
      chk($sformatf("vec%0d_mem_writes", i), nwr, vt[i].nwr);
      chk($sformatf("vec%0d_hit_count", i), 32'(hit_count), vt[i].hc);
      chk($sformatf("vec%0d_miss_count", i), 32'(miss_count), vt[i].mc);
      chk($sformatf("vec%0d_ready_while_busy", i), be, 0);
      chk($sformatf("vec%0d_mem_stability", i), ns, 0);
      for (int k = 0; k < vt[i].nrd && rd0 + k < rd_addr_q.size(); k++)
        chk($sformatf("vec%0d_fill_addr%0d", i, k), rd_addr_q[rd0 + k], {vt[i].addr[7:1], 1'(k)});
      if (vt[i].wr && wr0 < wr_addr_q.size()) begin
        chk($sformatf("vec%0d_wr_addr", i), wr_addr_q[wr0], vt[i].addr);
        chk($sformatf("vec%0d_wr_data", i), wr_data_q[wr0], vt[i].wdata);
      end
    end

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int n = 0; n < 150; n++) begin
      ra = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      model_txn($sformatf("rnd%0d", n), $urandom_range(0, 2) == 0, ra, $urandom,
                $urandom_range(1, 4));
    end
    for (int n = 0; n < 40; n++) model_txn($sformatf("sat%0d", n), 1'b0, 8'h09, '0, 1);
    chk("hit_count_saturated", 32'(hit_count), MAXC);

    // Abort a fill with reset right after its first block arrives.
    ack_lat = 1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h2A;
    @(posedge clk); #1;
    req_valid = 1'b0;
    got_ack = 1'b0;
    for (int c = 0; c < 20 && !got_ack; c++) begin
      @(negedge clk);
      if (mem_ack) begin
        got_ack = 1'b1;
        chk("abort_first_fill_write", cache_write_en, 1);
      end
    end
    chk("abort_saw_first_ack", got_ack, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("abort_mem_req", mem_req, 0);
    chk("abort_req_ready", req_ready, 1);
    chk("abort_hit_count", 32'(hit_count), 0);
    chk("abort_miss_count", 32'(miss_count), 0);
    cw0 = cw_cnt; rv0 = rv_cnt; ack0 = ack_cnt;
    @(posedge clk); #1;
    stray_req++;
    repeat (4) begin @(posedge clk); #1; end
    chk("stray_ack_seen", ack_cnt - ack0, 1);
    chk("stray_ack_cache_writes", cw_cnt - cw0, 0);
    chk("stray_ack_resp_valid", rv_cnt - rv0, 0);
    chk("stray_ack_req_ready", req_ready, 1);
    model_txn("post_abort", 1'b0, 8'h2B, '0, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- FSM between the CPU load/store port and the direct-mapped, write-through, no-write-allocate cache; directly upstream of the cache array.
- Drives the cache's write_en, write_data and address; consumes its hit and read_data (asynchronous read).
- On a read miss, fetches the whole line from memory block by block and fills the cache. Forwards every store to memory.

Parameters:
- LOG_NUM_LINES, 2, log2 of cache line count; must match the cache.
- LOG_NUM_BLOCKS, 1, log2 of blocks per line; must match the cache.
- DATA_WIDTH, 32, word width.
- ADDR_WIDTH, 8, word-address width.
- CNT_WIDTH, 16, width of the hit and miss statistics counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  store data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_WIDTH  load data, valid with resp_valid.
- cache_write_en  out  1  to cache write_en.
- cache_write_data  out  DATA_WIDTH  to cache write_data.
- cache_address  out  ADDR_WIDTH  to cache address.
- cache_hit  in  1  from cache hit.
- cache_read_data  in  DATA_WIDTH  from cache read_data.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write when 1.
- mem_addr  out  ADDR_WIDTH  memory word address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_ack  in  1  one-cycle completion; mem_rdata valid in the same cycle.
- mem_rdata  in  DATA_WIDTH  memory read data.
- hit_count  out  CNT_WIDTH  load hits since reset; saturating.
- miss_count  out  CNT_WIDTH  load misses since reset; saturating.

Behaviour:
- States: IDLE, LOOKUP, FILL, WRITE_MEM, DONE.
- Reset:
  - state = IDLE; block counter = 0.
  - req_ready = 1; resp_valid = 0; resp_rdata = 0.
  - cache_write_en = 0; mem_req = 0; mem_we = 0.
  - hit_count = 0; miss_count = 0.
  - Reset in any state, including mid-FILL or mid-WRITE_MEM, aborts the operation. mem_req drops the cycle after rst is sampled. A later mem_ack is ignored.
- IDLE:
  - req_ready = 1 only in IDLE.
  - On req_valid: latch addr, wdata and write flag; go to LOOKUP.
- cache_address:
  - Equals the latched address in LOOKUP, WRITE_MEM and DONE.
  - Equals {latched_addr[ADDR_WIDTH-1:LOG_NUM_BLOCKS], cnt} in FILL.
  - Don't-care in IDLE.
- LOOKUP (exactly one cycle):
  - Load, cache_hit = 1: capture cache_read_data into resp_rdata; hit_count += 1; go to DONE.
  - Load, cache_hit = 0: miss_count += 1; cnt = 0; go to FILL.
  - Store: if cache_hit = 1, assert cache_write_en with cache_write_data = wdata this cycle. Go to WRITE_MEM. No allocation on a store miss.
- FILL:
  - mem_req = 1, mem_we = 0, mem_addr = cache_address.
  - mem_addr is stable until mem_ack; mem_ack while mem_req = 0 is ignored.
  - On mem_ack: cache_write_en = 1 and cache_write_data = mem_rdata in that cycle.
  - If cnt == NUM_BLOCKS-1: go to DONE and capture resp_rdata from mem_rdata when cnt equals the requested block offset. Otherwise cnt += 1 and stay in FILL.
  - mem_req deasserts for at least the cycle after each mem_ack.
  - Fill order is block 0 upward; there is no critical-word-first.
- WRITE_MEM:
  - mem_req = 1, mem_we = 1, mem_addr = latched addr, mem_wdata = latched wdata.
  - On mem_ack: go to DONE.
- DONE (exactly one cycle):
  - resp_valid = 1. resp_rdata holds load data; it holds its previous value for stores.
  - Next state is IDLE.
- Latency, request acceptance to resp_valid:
  - Load hit: 2 cycles.
  - Store: 2 + memory ack latency.
  - Load miss: 2 + NUM_BLOCKS × (ack latency + 1).
- Counters saturate at 2^CNT_WIDTH-1 and do not wrap.
- Only one request is outstanding at a time. req_valid outside IDLE is not accepted; the CPU holds it.

Test Plan (defaults; after reset):
- Load 0x14, miss → mem reads 0x14 then 0x15, acked with 0xAAAA0001 and 0xAAAA0002 → two cache writes; resp_rdata = 0xAAAA0001; miss_count = 1.
- Then load 0x15 → hit; resp_valid exactly 2 cycles after acceptance; resp_rdata = 0xAAAA0002; no mem_req; hit_count = 1.
- Store 0x15 ← 0xDEADBEEF (hit) → cache_write_en in LOOKUP; mem write addr 0x15, data 0xDEADBEEF. Following load 0x15 returns 0xDEADBEEF with no mem_req.
- Store 0x40 ← 0x12345678 (miss) → mem write only; cache_write_en never asserted. Following load 0x40 misses; miss_count increments.
- mem_ack delayed 5 cycles on a fill → mem_req, mem_addr and mem_we stable throughout; req_ready = 0 until DONE.
- Assert rst the cycle after the first fill ack → next cycle mem_req = 0, req_ready = 1, counters = 0. A stray mem_ack two cycles later produces no cache write and no resp_valid.
